// File: rtl/dec_pkg.sv
// Shared definitions for the scanning one-hot decoder: mode encodings,
// FSM state type and the one-hot helper (index widths up to ONEHOT_MAX_W bits).
package dec_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;

  localparam int ONEHOT_MAX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10,
    ST_PULSE  = 2'b11
  } state_e;

  function automatic logic [(2**ONEHOT_MAX_W)-1:0] onehot(input logic [ONEHOT_MAX_W-1:0] idx);
    onehot = {{((2**ONEHOT_MAX_W)-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: load, decrement toward zero, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Registered binary-to-one-hot decoder with direct, auto-scan and timed one-shot modes.
// All outputs come straight from flops.
module decoder_scan_ctrl
  import dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                EN,
  input  logic [1:0]          MODE,
  input  logic [SEL_W-1:0]    W,
  input  logic                LOAD,
  input  logic [DWELL_W-1:0]  DWELL,
  output logic [2**SEL_W-1:0] Y,
  output logic [SEL_W-1:0]    IDX,
  output logic                BUSY,
  output logic                WRAP
);

  localparam int N = 2**SEL_W;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [N-1:0]       y_q, y_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [DWELL_W-1:0] cnt_value_s;
  logic [SEL_W-1:0]   idx_inc_s;

  assign idx_inc_s = idx_q + SEL_W'(1);

  dwell_counter #(.CNT_W(DWELL_W)) u_dwell (
    .clk_i   (Clock),
    .rst_ni  (Resetn),
    .load_i  (cnt_load_s),
    .value_i (cnt_value_s),
    .en_i    (cnt_dec_s),
    .zero_o  (cnt_zero_s)
  );

  // next-state and output decode; EN=0 keeps all state and blanks Y/WRAP
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    y_d         = '0;
    busy_d      = busy_q;
    wrap_d      = 1'b0;
    dwell_d     = dwell_q;
    cnt_load_s  = 1'b0;
    cnt_value_s = dwell_q;
    cnt_dec_s   = 1'b0;
    if (EN) begin
      case (state_q)
        ST_IDLE: begin
          idx_d  = '0;
          busy_d = 1'b0;
          if (MODE == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            idx_d   = W;
            y_d     = N'(onehot(ONEHOT_MAX_W'(W)));
          end else if (LOAD && ((MODE == MODE_SCAN) || (MODE == MODE_PULSE))) begin
            state_d     = (MODE == MODE_SCAN) ? ST_SCAN : ST_PULSE;
            idx_d       = W;
            y_d         = N'(onehot(ONEHOT_MAX_W'(W)));
            busy_d      = 1'b1;
            dwell_d     = DWELL;
            cnt_load_s  = 1'b1;
            cnt_value_s = DWELL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DIRECT: begin
          busy_d = 1'b0;
          if (MODE == MODE_DIRECT) begin
            idx_d = W;
            y_d   = N'(onehot(ONEHOT_MAX_W'(W)));
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
        ST_SCAN: begin
          if (MODE != MODE_SCAN) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else if (LOAD) begin
            idx_d       = W;
            y_d         = N'(onehot(ONEHOT_MAX_W'(W)));
            dwell_d     = DWELL;
            cnt_load_s  = 1'b1;
            cnt_value_s = DWELL;
          end else if (cnt_zero_s) begin
            idx_d       = idx_inc_s;
            y_d         = N'(onehot(ONEHOT_MAX_W'(idx_inc_s)));
            wrap_d      = &idx_q;
            cnt_load_s  = 1'b1;
            cnt_value_s = dwell_q;
          end else begin
            y_d       = N'(onehot(ONEHOT_MAX_W'(idx_q)));
            cnt_dec_s = 1'b1;
          end
        end
        ST_PULSE: begin
          // LOAD is deliberately ignored here: a pulse is never retriggered
          if ((MODE != MODE_PULSE) || cnt_zero_s) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
          end else begin
            y_d       = N'(onehot(ONEHOT_MAX_W'(idx_q)));
            cnt_dec_s = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // state and output registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      dwell_q <= dwell_d;
    end
  end

  assign Y    = y_q;
  assign IDX  = idx_q;
  assign BUSY = busy_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench: default instance (SEL_W=3, DWELL_W=8) and a SEL_W=4, DWELL_W=1 instance.
module tb_decoder_scan_ctrl;

  typedef struct {
    logic [15:0] y;
    logic [3:0]  idx;
    logic        busy;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0, load = 1'b0;
  logic [1:0]  mode = 2'b11;
  logic [2:0]  w = 3'd0;
  logic [7:0]  dwell = 8'd0;
  logic [7:0]  y;
  logic [2:0]  idx;
  logic        busy, wrap;

  logic        en2 = 1'b0, load2 = 1'b0;
  logic [1:0]  mode2 = 2'b11;
  logic [3:0]  w2 = 4'd0;
  logic [0:0]  dwell2 = 1'b0;
  logic [15:0] y2;
  logic [3:0]  idx2;
  logic        busy2, wrap2;

  exp_t sb[$];
  exp_t sb2[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.SEL_W(3), .DWELL_W(8)) dut (
    .Clock(clk), .Resetn(rstn), .EN(en), .MODE(mode), .W(w), .LOAD(load), .DWELL(dwell),
    .Y(y), .IDX(idx), .BUSY(busy), .WRAP(wrap)
  );

  decoder_scan_ctrl #(.SEL_W(4), .DWELL_W(1)) dut2 (
    .Clock(clk), .Resetn(rstn), .EN(en2), .MODE(mode2), .W(w2), .LOAD(load2), .DWELL(dwell2),
    .Y(y2), .IDX(idx2), .BUSY(busy2), .WRAP(wrap2)
  );

  function automatic exp_t mk(input logic [15:0] ey, input int ei, input logic eb, input logic ew);
    exp_t e;
    e.y = ey; e.idx = 4'(ei); e.busy = eb; e.wrap = ew;
    return e;
  endfunction

  function automatic logic [15:0] oh(input int i);
    return 16'd1 << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0;
    tick();
    sb.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
    sb2.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
    tick();
    e = sb.pop_front();
    checks++;
    if ({8'h00, y} !== e.y || {1'b0, idx} !== e.idx || busy !== e.busy || wrap !== e.wrap) begin
      errors++;
      $display("FAIL reset_init: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
               y, idx, busy, wrap, e.y, e.idx, e.busy, e.wrap);
    end
    e = sb2.pop_front();
    checks++;
    if (y2 !== e.y || idx2 !== e.idx || busy2 !== e.busy || wrap2 !== e.wrap) begin
      errors++;
      $display("FAIL reset_init2: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
               y2, idx2, busy2, wrap2, e.y, e.idx, e.busy, e.wrap);
    end
    // start a scan, then reset it mid-flight
    rstn = 1'b1; en = 1'b1; mode = 2'b01; w = 3'd2; dwell = 8'd1; load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) load = 1'b0;
      if (k == 3 || k == 4) rstn = 1'b0;
      if (k == 5) rstn = 1'b1;
      if (k < 2) sb.push_back(mk(oh(2), 2, 1'b1, 1'b0));
      else if (k == 2) sb.push_back(mk(oh(3), 3, 1'b1, 1'b0));
      else sb.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({8'h00, y} !== e.y || {1'b0, idx} !== e.idx || busy !== e.busy || wrap !== e.wrap) begin
        errors++;
        $display("FAIL reset_scan k=%0d: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
                 k, y, idx, busy, wrap, e.y, e.idx, e.busy, e.wrap);
      end
    end
    mode = 2'b11;
  endtask

  task automatic test_direct();
    exp_t e;
    en = 1'b1; mode = 2'b00; load = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        w = 3'(k);
        sb.push_back(mk(oh(k), k, 1'b0, 1'b0));
      end else if (k == 8) begin
        en = 1'b0; w = 3'd2;
        sb.push_back(mk(16'h0000, 7, 1'b0, 1'b0));
      end else if (k == 9) begin
        en = 1'b1; w = 3'd5;
        sb.push_back(mk(oh(5), 5, 1'b0, 1'b0));
      end else begin
        mode = 2'b11;
        sb.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      checks++;
      if ({8'h00, y} !== e.y || {1'b0, idx} !== e.idx || busy !== e.busy || wrap !== e.wrap) begin
        errors++;
        $display("FAIL direct k=%0d: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
                 k, y, idx, busy, wrap, e.y, e.idx, e.busy, e.wrap);
      end
    end
  endtask

  task automatic test_scan();
    exp_t e;
    en = 1'b1; mode = 2'b01; w = 3'd6; dwell = 8'd2; load = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 1) load = 1'b0;
      if (k < 11) begin
        sb.push_back(mk(oh((6 + k / 3) % 8), (6 + k / 3) % 8, 1'b1, k == 6));
      end else if (k == 11) begin
        w = 3'd4; load = 1'b1;
        sb.push_back(mk(oh(4), 4, 1'b1, 1'b0));
      end else begin
        load = 1'b0; mode = 2'b11;
        sb.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      checks++;
      if ({8'h00, y} !== e.y || {1'b0, idx} !== e.idx || busy !== e.busy || wrap !== e.wrap) begin
        errors++;
        $display("FAIL scan k=%0d: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
                 k, y, idx, busy, wrap, e.y, e.idx, e.busy, e.wrap);
      end
    end
  endtask

  task automatic test_pulse();
    exp_t e;
    en = 1'b1; mode = 2'b10; w = 3'd3; dwell = 8'd4;
    for (int k = 0; k < 12; k++) begin
      load = (k == 0 || k == 2 || k == 7 || k == 9) ? 1'b1 : 1'b0;
      w = (k == 2) ? 3'd5 : (k == 7) ? 3'd7 : (k == 9) ? 3'd2 : 3'd3;
      if (k == 7) dwell = 8'd0;
      if (k == 9) dwell = 8'd4;
      if (k == 11) mode = 2'b11;
      if (k < 5) sb.push_back(mk(oh(3), 3, 1'b1, 1'b0));
      else if (k == 7) sb.push_back(mk(oh(7), 7, 1'b1, 1'b0));
      else if (k == 9 || k == 10) sb.push_back(mk(oh(2), 2, 1'b1, 1'b0));
      else sb.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({8'h00, y} !== e.y || {1'b0, idx} !== e.idx || busy !== e.busy || wrap !== e.wrap) begin
        errors++;
        $display("FAIL pulse k=%0d: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
                 k, y, idx, busy, wrap, e.y, e.idx, e.busy, e.wrap);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    en = 1'b1; mode = 2'b10; w = 3'd6; dwell = 8'd0; load = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) sb.push_back(mk(oh(6), 6, 1'b1, 1'b0));
      else sb.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({8'h00, y} !== e.y || {1'b0, idx} !== e.idx || busy !== e.busy || wrap !== e.wrap) begin
        errors++;
        $display("FAIL back_to_back k=%0d: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
                 k, y, idx, busy, wrap, e.y, e.idx, e.busy, e.wrap);
      end
    end
    load = 1'b0; mode = 2'b11;
    tick();
  endtask

  task automatic test_en_pause();
    exp_t e;
    en = 1'b1; mode = 2'b01; w = 3'd5; dwell = 8'd3; load = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k == 1) load = 1'b0;
      en = (k >= 2 && k < 7) ? 1'b0 : 1'b1;
      if (k == 10) mode = 2'b11;
      if (k < 2 || k == 7 || k == 8) sb.push_back(mk(oh(5), 5, 1'b1, 1'b0));
      else if (k < 7) sb.push_back(mk(16'h0000, 5, 1'b1, 1'b0));
      else if (k == 9) sb.push_back(mk(oh(6), 6, 1'b1, 1'b0));
      else sb.push_back(mk(16'h0000, 0, 1'b0, 1'b0));
      tick();
      e = sb.pop_front();
      checks++;
      if ({8'h00, y} !== e.y || {1'b0, idx} !== e.idx || busy !== e.busy || wrap !== e.wrap) begin
        errors++;
        $display("FAIL en_pause k=%0d: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
                 k, y, idx, busy, wrap, e.y, e.idx, e.busy, e.wrap);
      end
    end
  endtask

  task automatic test_params();
    exp_t e;
    int   wraps = 0;
    en2 = 1'b1; mode2 = 2'b01; w2 = 4'd14; dwell2 = 1'b0; load2 = 1'b1;
    for (int k = 0; k < 34; k++) begin
      if (k == 1) load2 = 1'b0;
      sb2.push_back(mk(oh((14 + k) % 16), (14 + k) % 16, 1'b1, (k > 0) && ((14 + k) % 16 == 0)));
      tick();
      e = sb2.pop_front();
      if (wrap2 === 1'b1) wraps++;
      checks++;
      if (y2 !== e.y || idx2 !== e.idx || busy2 !== e.busy || wrap2 !== e.wrap) begin
        errors++;
        $display("FAIL params k=%0d: got y=%h idx=%0d busy=%b wrap=%b, expected y=%h idx=%0d busy=%b wrap=%b",
                 k, y2, idx2, busy2, wrap2, e.y, e.idx, e.busy, e.wrap);
      end
    end
    checks++;
    if (wraps !== 2) begin
      errors++;
      $display("FAIL params_wrap_count: got %0d, expected 2", wraps);
    end
    mode2 = 2'b11;
    tick();
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_pulse();
    test_back_to_back();
    test_en_pause();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
